// File: rtl/adder_meas_pkg.sv
// Shared FSM state type and default widths for the adder delay measurement controller.
package adder_meas_pkg;

    localparam int SETTLE_W_DEF      = 8;
    localparam int RUN_W_DEF         = 16;
    localparam int FREEZE_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        RUN,
        FREEZE,
        CAPTURE,
        DONE
    } meas_state_t;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/meas_down_counter.sv
// Loadable down counter with a zero flag; it saturates at zero instead of wrapping.
module meas_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/adder_measure_ctrl.sv
// Sequences one ring-oscillator delay measurement of an adder: clear, settle, run, freeze,
// then capture the ring count and the adder sum, checking the sum against the operands.
module adder_measure_ctrl
    import adder_meas_pkg::*;
#(
    parameter int SETTLE_W      = SETTLE_W_DEF,
    parameter int RUN_W         = RUN_W_DEF,
    parameter int FREEZE_CYCLES = FREEZE_CYCLES_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    input  logic                abort,
    input  logic [31:0]         a_in,
    input  logic [31:0]         b_in,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic [RUN_W-1:0]    run_cycles,
    input  logic [31:0]         ring_count_i,
    input  logic [31:0]         sum_i,
    output logic [31:0]         a_out,
    output logic [31:0]         b_out,
    output logic                ring_en,
    output logic                count_clr,
    output logic                busy,
    output logic                done,
    output logic [31:0]         count_o,
    output logic [31:0]         sum_o,
    output logic                sum_ok
);

    localparam int CNT_W = max_int(max_int(SETTLE_W, RUN_W), $clog2(FREEZE_CYCLES + 1));

    meas_state_t          state, state_nxt;
    logic [31:0]          a_q, b_q;
    logic [SETTLE_W-1:0]  settle_q;
    logic [RUN_W-1:0]     run_q;
    logic                 latch;
    logic                 cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0]     cnt_val;
    logic [CNT_W-1:0]     settle_load, run_load, freeze_load;

    assign latch       = (state == IDLE) && start && !abort;
    // Each timed phase is loaded with N-1 and leaves when the counter reads zero.
    assign settle_load = CNT_W'(settle_q) - CNT_W'(1);
    assign run_load    = CNT_W'(run_q) - CNT_W'(1);
    assign freeze_load = CNT_W'(FREEZE_CYCLES - 1);
    assign cnt_en      = (state == SETTLE) || (state == RUN) || (state == FREEZE);

    meas_down_counter #(.W(CNT_W)) u_counter (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        case (state)
            IDLE: begin
                if (latch) state_nxt = CLEAR;
            end
            CLEAR: begin
                cnt_load = 1'b1;
                if (settle_q != '0) begin
                    state_nxt = SETTLE;
                    cnt_val   = settle_load;
                end else if (run_q != '0) begin
                    state_nxt = RUN;
                    cnt_val   = run_load;
                end else begin
                    state_nxt = FREEZE;
                    cnt_val   = freeze_load;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (run_q != '0) begin
                        state_nxt = RUN;
                        cnt_val   = run_load;
                    end else begin
                        state_nxt = FREEZE;
                        cnt_val   = freeze_load;
                    end
                end
            end
            RUN: begin
                if (cnt_zero) begin
                    state_nxt = FREEZE;
                    cnt_load  = 1'b1;
                    cnt_val   = freeze_load;
                end
            end
            FREEZE: begin
                if (cnt_zero) state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            cnt_load  = 1'b0;
        end
    end

    always_comb begin
        ring_en   = (state == RUN);
        count_clr = (state == CLEAR);
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            settle_q <= '0;
            run_q    <= '0;
        end else if (latch) begin
            a_q      <= a_in;
            b_q      <= b_in;
            settle_q <= settle_cycles;
            run_q    <= run_cycles;
        end
    end

    // An abort landing on CAPTURE leaves the previous results untouched.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            count_o <= '0;
            sum_o   <= '0;
            sum_ok  <= 1'b0;
        end else if ((state == CAPTURE) && !abort) begin
            count_o <= ring_count_i;
            sum_o   <= sum_i;
            sum_ok  <= (sum_i == a_q + b_q);
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// Directed bench for adder_measure_ctrl: table of measurement vectors plus abort, restart and reset sequences.
module tb_adder_measure_ctrl;

    localparam int MAXC = 400;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start, abort;
    logic [31:0] a_in, b_in, ring_count_i, sum_i;
    logic [7:0]  settle_cycles;
    logic [15:0] run_cycles;
    logic [31:0] a_out, b_out, count_o, sum_o;
    logic        ring_en, count_clr, busy, done, sum_ok;

    int pass_count  = 0;
    int check_count = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          settle;
        int          run;
        logic [31:0] sum;
        logic [31:0] ring;
        int          exp_lat;
        int          exp_ring;
        logic        exp_ok;
    } vec_t;

    vec_t vt[7];

    adder_measure_ctrl dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .start         (start),
        .abort         (abort),
        .a_in          (a_in),
        .b_in          (b_in),
        .settle_cycles (settle_cycles),
        .run_cycles    (run_cycles),
        .ring_count_i  (ring_count_i),
        .sum_i         (sum_i),
        .a_out         (a_out),
        .b_out         (b_out),
        .ring_en       (ring_en),
        .count_clr     (count_clr),
        .busy          (busy),
        .done          (done),
        .count_o       (count_o),
        .sum_o         (sum_o),
        .sum_ok        (sum_ok)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Pulses start for one edge and tallies outputs after each edge until busy falls.
    task automatic applyStimulus(input vec_t v, input int repulse_at, output int done_at,
                                 output int ring_c, output int clr_c, output int busy_c, output int done_c);
        done_at = -1; ring_c = 0; clr_c = 0; busy_c = 0; done_c = 0;
        @(negedge wb_clk_i);
        a_in = v.a; b_in = v.b;
        settle_cycles = 8'(v.settle); run_cycles = 16'(v.run);
        sum_i = v.sum; ring_count_i = v.ring;
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            if (ring_en)   ring_c++;
            if (count_clr) clr_c++;
            if (busy)      busy_c++;
            if (done) begin
                done_c++;
                if (done_at < 0) done_at = i;
            end
            if (!busy) break;
            if (i == repulse_at) begin
                start = 1'b1; a_in = 32'h9; b_in = 32'h9;
            end else if (i == repulse_at + 1) begin
                start = 1'b0;
            end
            @(negedge wb_clk_i);
        end
        start = 1'b0;
    endtask

    initial begin
        int done_at, ring_c, clr_c, busy_c, done_c, rc;
        vec_t rv;

        vt[0] = '{32'h5,        32'h7,        2,   10, 32'hC,   32'h1234, 16,  10, 1'b1};
        vt[1] = '{32'hFFFFFFFF, 32'h1,        1,   3,  32'h0,   32'h11,   8,   3,  1'b1};
        vt[2] = '{32'hFFFFFFFF, 32'h1,        1,   3,  32'h1,   32'h22,   8,   3,  1'b0};
        vt[3] = '{32'h10,       32'h20,       0,   0,  32'h30,  32'hABCD, 4,   0,  1'b1};
        vt[4] = '{32'h100,      32'h200,      3,   0,  32'h999, 32'h5,    7,   0,  1'b0};
        vt[5] = '{32'h80000000, 32'h80000000, 0,   5,  32'h0,   32'h66,   9,   5,  1'b1};
        vt[6] = '{32'h1,        32'h1,        255, 1,  32'h2,   32'h44,   260, 1,  1'b1};

        wb_rst_i = 1'b1; start = 1'b0; abort = 1'b0;
        a_in = '0; b_in = '0; settle_cycles = '0; run_cycles = '0;
        ring_count_i = '0; sum_i = '0;
        #12;
        checkOutput("rst_busy",    32'(busy),    32'h0);
        checkOutput("rst_ring_en", 32'(ring_en), 32'h0);
        checkOutput("rst_done",    32'(done),    32'h0);
        checkOutput("rst_clr",     32'(count_clr), 32'h0);
        checkOutput("rst_a_out",   a_out,        32'h0);
        checkOutput("rst_count_o", count_o,      32'h0);
        checkOutput("rst_sum_ok",  32'(sum_ok),  32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        for (int t = 0; t < 7; t++) begin
            applyStimulus(vt[t], -1, done_at, ring_c, clr_c, busy_c, done_c);
            checkOutput($sformatf("v%0d_latency", t),   32'(done_at), 32'(vt[t].exp_lat));
            checkOutput($sformatf("v%0d_ring_cyc", t),  32'(ring_c),  32'(vt[t].exp_ring));
            checkOutput($sformatf("v%0d_busy_cyc", t),  32'(busy_c),  32'(vt[t].exp_lat + 1));
            checkOutput($sformatf("v%0d_clr_cyc", t),   32'(clr_c),   32'h1);
            checkOutput($sformatf("v%0d_done_cnt", t),  32'(done_c),  32'h1);
            checkOutput($sformatf("v%0d_count_o", t),   count_o,      vt[t].ring);
            checkOutput($sformatf("v%0d_sum_o", t),     sum_o,        vt[t].sum);
            checkOutput($sformatf("v%0d_sum_ok", t),    32'(sum_ok),  32'(vt[t].exp_ok));
            checkOutput($sformatf("v%0d_a_out", t),     a_out,        vt[t].a);
            checkOutput($sformatf("v%0d_b_out", t),     b_out,        vt[t].b);
        end

        rv = '{32'h3, 32'h4, 2, 4, 32'h7, 32'h77, 10, 4, 1'b1};
        applyStimulus(rv, 3, done_at, ring_c, clr_c, busy_c, done_c);
        checkOutput("repulse_latency",  32'(done_at), 32'd10);
        checkOutput("repulse_done_cnt", 32'(done_c),  32'h1);
        checkOutput("repulse_a_out",    a_out,        32'h3);
        checkOutput("repulse_b_out",    b_out,        32'h4);
        checkOutput("repulse_sum_ok",   32'(sum_ok),  32'h1);

        @(negedge wb_clk_i);
        a_in = 32'h1; b_in = 32'h2; settle_cycles = 8'd1; run_cycles = 16'd10;
        sum_i = 32'hDEAD; ring_count_i = 32'hBEEF;
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        rc = 0;
        for (int i = 0; i < 50; i++) begin
            if (ring_en) rc++;
            if (rc == 5) break;
            @(negedge wb_clk_i);
        end
        checkOutput("abort_reach_run5", 32'(rc), 32'd5);
        abort = 1'b1;
        @(posedge wb_clk_i);
        #1;
        checkOutput("abort_ring_en", 32'(ring_en), 32'h0);
        checkOutput("abort_busy",    32'(busy),    32'h0);
        @(negedge wb_clk_i);
        abort = 1'b0;
        done_c = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) done_c++;
            @(negedge wb_clk_i);
        end
        checkOutput("abort_no_done", 32'(done_c), 32'h0);
        checkOutput("abort_count_o", count_o,      32'h77);
        checkOutput("abort_sum_o",   sum_o,        32'h7);
        checkOutput("abort_sum_ok",  32'(sum_ok),  32'h1);

        start = 1'b1; abort = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0; abort = 1'b0;
        busy_c = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || done) busy_c++;
            @(negedge wb_clk_i);
        end
        checkOutput("start_abort_idle", 32'(busy_c), 32'h0);

        a_in = 32'h11; b_in = 32'h22; settle_cycles = 8'd0; run_cycles = 16'd10;
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        rc = 0;
        for (int i = 0; i < 50; i++) begin
            if (ring_en) rc++;
            if (rc == 3) break;
            @(negedge wb_clk_i);
        end
        checkOutput("rst_reach_run", 32'(rc), 32'd3);
        #2;
        wb_rst_i = 1'b1;
        #1;
        checkOutput("midrst_ring_en", 32'(ring_en), 32'h0);
        checkOutput("midrst_busy",    32'(busy),    32'h0);
        checkOutput("midrst_done",    32'(done),    32'h0);
        checkOutput("midrst_a_out",   a_out,        32'h0);
        checkOutput("midrst_b_out",   b_out,        32'h0);
        checkOutput("midrst_count_o", count_o,      32'h0);
        checkOutput("midrst_sum_o",   sum_o,        32'h0);
        checkOutput("midrst_sum_ok",  32'(sum_ok),  32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        applyStimulus(vt[0], -1, done_at, ring_c, clr_c, busy_c, done_c);
        checkOutput("post_rst_latency", 32'(done_at), 32'd16);
        checkOutput("post_rst_sum_o",   sum_o,        32'hC);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/adder_measure_ctrl.md
ADDER_MEASURE_CTRL -- requirements
Module: adder_measure_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_W, default 8, width of settle-cycle count.
REQ-002 SHALL have parameter RUN_W, default 16, width of run-cycle count.
REQ-003 SHALL have parameter FREEZE_CYCLES, default 2, ring-stop to capture wait.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock.
REQ-005 SHALL have port wb_rst_i  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports start  in  1  begin measurement; abort  in  1  cancel measurement.
REQ-007 SHALL have ports a_in, b_in  in  32  operands; settle_cycles  in  SETTLE_W; run_cycles  in  RUN_W.
REQ-008 SHALL have ports ring_count_i  in  32  ring counter value; sum_i  in  32  adder sum.
REQ-009 SHALL have ports a_out, b_out  out  32  operands to adder.
REQ-010 SHALL have ports ring_en  out  1  ring enable; count_clr  out  1  ring counter clear.
REQ-011 SHALL have ports busy, done  out  1; count_o, sum_o  out  32  results; sum_ok  out  1  sum check.

Function
REQ-012 SHALL implement FSM states IDLE, CLEAR, SETTLE, RUN, FREEZE, CAPTURE, DONE.
REQ-013 IDLE: start=1 at edge SHALL latch a_in, b_in, settle_cycles, run_cycles; next state CLEAR.
REQ-014 start SHALL be ignored outside IDLE.
REQ-015 CLEAR: count_clr=1 for exactly one cycle; next SETTLE, or RUN if settle=0, or FREEZE if settle=0 and run=0.
REQ-016 a_out/b_out SHALL drive latched operands from CLEAR onward, held until next latch.
REQ-017 SETTLE SHALL last exactly latched settle cycles; ring_en=0.
REQ-018 RUN SHALL last exactly latched run cycles with ring_en=1; run=0 skips RUN (ring_en never asserted).
REQ-019 FREEZE SHALL last FREEZE_CYCLES cycles with ring_en=0.
REQ-020 CAPTURE (one cycle): count_o<=ring_count_i, sum_o<=sum_i, sum_ok<=(sum_i == latched a+b mod 2^32).
REQ-021 DONE SHALL last one cycle with done=1, then IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE; ring_en SHALL be 1 only in RUN.
REQ-023 Latency: start sampled at edge k -> done high for cycle after edge k+2+S+R+F.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE at next edge, ring_en=0 then, results unchanged, no done.
REQ-025 abort and start same edge in IDLE: abort wins, no measurement.
REQ-026 Counters SHALL not wrap: max settle/run values give exactly 2^W-1 cycles.
REQ-027 count_o, sum_o, sum_ok SHALL hold until next CAPTURE.

Reset
REQ-028 wb_rst_i=1 SHALL immediately force IDLE, independent of wb_rst_i-clock alignment.
REQ-029 Reset values: all outputs 0 (a_out, b_out, count_o, sum_o, sum_ok, ring_en, count_clr, busy, done).
REQ-030 Reset mid-RUN SHALL drop ring_en asynchronously and discard the measurement.

Structure
REQ-031 Package adder_meas_pkg SHALL hold FSM state enum and default width constants.
REQ-032 One sub-module meas_down_counter (loadable, zero flag) SHALL be shared across SETTLE/RUN/FREEZE timing.

Verification
REQ-033 a=5, b=7, S=2, R=10, F=2, start pulse -> count_clr 1 cycle, ring_en exactly 10 cycles, done 16 edges after start, busy 17 cycles, sum_o=12 with sum_i=12, sum_ok=1.
REQ-034 a=0xFFFFFFFF, b=1, sum_i=0 -> sum_ok=1; sum_i=1 -> sum_ok=0.
REQ-035 S=0, R=0 -> ring_en never high, done 4 edges after start, count_o=ring_count_i.
REQ-036 abort during RUN cycle 5 -> ring_en low next edge, IDLE, no done, prior results retained.
REQ-037 wb_rst_i asserted mid-RUN between edges -> ring_en, busy low immediately; all outputs 0.
REQ-038 start re-pulsed while busy -> ignored; operands unchanged; single done.
